// File: rtl/wrr_pop_scheduler.sv
// wrr_pop_scheduler: weighted round-robin pop scheduler for four input FIFOs
// draining into one shared downstream FIFO.
//
// A queue is granted in IDLE. It may then pop for up to its programmed weight
// in consecutive SERVE cycles. The burst stops early when the queue runs
// empty, and it stalls while the downstream path signals almost-full.
// out_valid/out_id trail pop by one cycle, which matches the FIFO read
// latency of 1.
//
// Optional feature (macro WRR_STATS_EN): per-queue saturating 8-bit pop
// counters on pop_count, cleared by stats_clr. The default build has no
// counters and no stats ports.
module wrr_pop_scheduler #(
    parameter int NUM_Q = 4,
    parameter int ID_W  = 2,
    parameter int WGT_W = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_Q-1:0]       empty,
    input  logic [NUM_Q*WGT_W-1:0] weights,
    input  logic                   down_almost_full,
    output logic [NUM_Q-1:0]       pop,
    output logic [ID_W-1:0]        id,
    output logic                   out_valid,
    output logic [ID_W-1:0]        out_id
`ifdef WRR_STATS_EN
    ,
    input  logic                   stats_clr,
    output logic [8*NUM_Q-1:0]     pop_count
`endif
);

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } state_t;

    state_t           state;
    logic [ID_W-1:0]  cur;
    logic [WGT_W-1:0] credit;

    logic [WGT_W-1:0] wgt [NUM_Q];
    logic [NUM_Q-1:0] elig;
    logic             found;
    logic [ID_W-1:0]  pick;
    logic [ID_W-1:0]  cand;
    logic             fire;

    // Unpack the weight bus and work out which queues may be granted.
    always_comb begin
        for (int i = 0; i < NUM_Q; i++) begin
            wgt[i]  = weights[WGT_W*i +: WGT_W];
            elig[i] = ~empty[i] & (weights[WGT_W*i +: WGT_W] != '0);
        end
    end

    // Round-robin search: cur+1, cur+2, cur+3, then cur itself (mod NUM_Q).
    always_comb begin
        found = 1'b0;
        pick  = cur;
        cand  = cur;
        for (int k = 1; k <= NUM_Q; k++) begin
            cand = cur + ID_W'(k);
            if (!found && elig[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // A pop fires only for the granted queue while it has data and downstream has room.
    always_comb begin
        fire = (state == SERVE) & ~empty[cur] & ~down_almost_full & ~reset;
        pop  = '0;
        if (fire) begin
            pop[cur] = 1'b1;
        end
    end

    // Grant/serve state machine: load credit at grant, count it down per pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cur    <= ID_W'(NUM_Q - 1);
            credit <= '0;
            id     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state  <= SERVE;
                        cur    <= pick;
                        id     <= pick;
                        credit <= wgt[pick];
                    end
                end
                SERVE: begin
                    if (fire) begin
                        if (credit > WGT_W'(1)) begin
                            credit <= credit - WGT_W'(1);
                        end else begin
                            credit <= '0;
                            state  <= IDLE;
                        end
                    end else if (empty[cur]) begin
                        // Queue drained: any remaining credit is discarded.
                        credit <= '0;
                        state  <= IDLE;
                    end
                    // Otherwise back-pressure: hold state and credit.
                end
                default: begin
                    state  <= IDLE;
                    credit <= '0;
                end
            endcase
        end
    end

    // Output tag: the FIFO data for this cycle's pop appears next cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_id    <= '0;
        end else begin
            out_valid <= |pop;
            out_id    <= cur;
        end
    end

`ifdef WRR_STATS_EN
    logic [7:0] cnt [NUM_Q];

    // Per-queue saturating pop counters; a clear wins over a coincident pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_Q; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_Q; i++) begin
                if (stats_clr) begin
                    cnt[i] <= '0;
                end else if (pop[i] && (cnt[i] != 8'hFF)) begin
                    cnt[i] <= cnt[i] + 8'd1;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_Q; g++) begin : g_cnt
        assign pop_count[8*g +: 8] = cnt[g];
    end
`endif

endmodule

// File: tb/tb_wrr_pop_scheduler.sv
// Testbench for wrr_pop_scheduler: directed per-cycle vectors push expected
// pop/id/out_valid/out_id into a scoreboard queue; a monitor on the falling
// edge pops each entry and compares it against the DUT.
module tb_wrr_pop_scheduler;

    logic        clk;
    logic        reset;
    logic [3:0]  empty;
    logic [11:0] weights;
    logic        down_almost_full;
    logic [3:0]  pop;
    logic [1:0]  id;
    logic        out_valid;
    logic [1:0]  out_id;
`ifdef WRR_STATS_EN
    logic        stats_clr;
    logic [31:0] pop_count;
`endif

    wrr_pop_scheduler #(.NUM_Q(4), .ID_W(2), .WGT_W(3)) dut (
        .clk              (clk),
        .reset            (reset),
        .empty            (empty),
        .weights          (weights),
        .down_almost_full (down_almost_full),
        .pop              (pop),
        .id               (id),
        .out_valid        (out_valid),
        .out_id           (out_id)
`ifdef WRR_STATS_EN
        ,
        .stats_clr        (stats_clr),
        .pop_count        (pop_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         tag;
        logic [3:0] pop;
        logic       ov;
        logic [1:0] oid;
        logic       chk_oid;
        logic [1:0] idv;
        logic       chk_id;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc_n    = 0;
    logic [3:0] prev_pop;

    function automatic logic [1:0] oh2i(input logic [3:0] v);
        case (v)
            4'b0010: return 2'd1;
            4'b0100: return 2'd2;
            4'b1000: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [11:0] wv(input int w3, input int w2, input int w1, input int w0);
        return {3'(w3), 3'(w2), 3'(w1), 3'(w0)};
    endfunction

    task automatic chk(input string nm, input int tag, input int got, input int want);
        n_checks++;
        if (got == want) n_pass++;
        else $display("FAIL %s cycle %0d: got %0d want %0d", nm, tag, got, want);
    endtask

    // Monitor: compare DUT outputs against the scoreboard on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("pop", e.tag, int'(pop), int'(e.pop));
                chk("out_valid", e.tag, int'(out_valid), int'(e.ov));
                if (e.chk_oid) chk("out_id", e.tag, int'(out_id), int'(e.oid));
                if (e.chk_id)  chk("id", e.tag, int'(id), int'(e.idv));
            end
        end
    end

    task automatic push(input logic [3:0] ep, input logic rst_cyc);
        exp_t e;
        e.tag     = cyc_n;
        e.pop     = ep;
        e.ov      = rst_cyc ? 1'b0 : |prev_pop;
        e.oid     = rst_cyc ? 2'd0 : oh2i(prev_pop);
        e.chk_oid = rst_cyc ? 1'b1 : |prev_pop;
        e.idv     = rst_cyc ? 2'd0 : oh2i(ep);
        e.chk_id  = rst_cyc ? 1'b1 : |ep;
        sb.push_back(e);
        prev_pop  = rst_cyc ? 4'b0000 : ep;
        cyc_n++;
    endtask

    task automatic cyc(input logic [11:0] w, input logic [3:0] e, input logic af,
                       input logic [3:0] ep);
        @(posedge clk);
        #1;
        reset            = 1'b0;
        weights          = w;
        empty            = e;
        down_almost_full = af;
        push(ep, 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        push(4'b0000, 1'b1);
    endtask

    initial begin
        logic [11:0] w;
        reset            = 1'b1;
        empty            = 4'b1111;
        weights          = '0;
        down_almost_full = 1'b0;
        prev_pop         = 4'b0000;
`ifdef WRR_STATS_EN
        stats_clr        = 1'b0;
`endif

        // All weights 1, all queues non-empty: one pop per queue with bubbles.
        do_reset();
        w = wv(1, 1, 1, 1);
        cyc(w, 4'b0000, 1'b0, 4'b0000);
        cyc(w, 4'b0000, 1'b0, 4'b0001);
        cyc(w, 4'b0000, 1'b0, 4'b0000);
        cyc(w, 4'b0000, 1'b0, 4'b0010);
        cyc(w, 4'b0000, 1'b0, 4'b0000);
        cyc(w, 4'b0000, 1'b0, 4'b0100);
        cyc(w, 4'b0000, 1'b0, 4'b0000);
        cyc(w, 4'b0000, 1'b0, 4'b1000);
        cyc(w, 4'b0000, 1'b0, 4'b0000);
        cyc(w, 4'b0000, 1'b0, 4'b0001);

        // q0 weight 3: burst of three, then single pops for q1, q2, q3.
        do_reset();
        w = wv(1, 1, 1, 3);
        cyc(w, 4'b0000, 1'b0, 4'b0000);
        cyc(w, 4'b0000, 1'b0, 4'b0001);
        cyc(w, 4'b0000, 1'b0, 4'b0001);
        cyc(w, 4'b0000, 1'b0, 4'b0001);
        cyc(w, 4'b0000, 1'b0, 4'b0000);
        cyc(w, 4'b0000, 1'b0, 4'b0010);
        cyc(w, 4'b0000, 1'b0, 4'b0000);
        cyc(w, 4'b0000, 1'b0, 4'b0100);
        cyc(w, 4'b0000, 1'b0, 4'b0000);
        cyc(w, 4'b0000, 1'b0, 4'b1000);

        // q1 weight 4 with three cycles of back-pressure after the first pop.
        do_reset();
        w = wv(0, 0, 4, 0);
        cyc(w, 4'b0000, 1'b0, 4'b0000);
        cyc(w, 4'b0000, 1'b0, 4'b0010);
        cyc(w, 4'b0000, 1'b1, 4'b0000);
        cyc(w, 4'b0000, 1'b1, 4'b0000);
        cyc(w, 4'b0000, 1'b1, 4'b0000);
        cyc(w, 4'b0000, 1'b0, 4'b0010);
        cyc(w, 4'b0000, 1'b0, 4'b0010);
        cyc(w, 4'b0000, 1'b0, 4'b0010);
        cyc(w, 4'b0000, 1'b0, 4'b0000);
        cyc(w, 4'b0000, 1'b0, 4'b0010);

        // q2 empty, q3 weight 0: only q0/q1 served, two pops each.
        do_reset();
        w = wv(0, 1, 2, 2);
        cyc(w, 4'b0100, 1'b0, 4'b0000);
        cyc(w, 4'b0100, 1'b0, 4'b0001);
        cyc(w, 4'b0100, 1'b0, 4'b0001);
        cyc(w, 4'b0100, 1'b0, 4'b0000);
        cyc(w, 4'b0100, 1'b0, 4'b0010);
        cyc(w, 4'b0100, 1'b0, 4'b0010);
        cyc(w, 4'b0100, 1'b0, 4'b0000);
        cyc(w, 4'b0100, 1'b0, 4'b0001);

        // q0 weight 6 drains after 2 pops (with almost_full in the same cycle);
        // q1 is granted, then q0 is regranted with a full fresh credit of 6.
        do_reset();
        w = wv(0, 0, 1, 6);
        cyc(w, 4'b0000, 1'b0, 4'b0000);
        cyc(w, 4'b0000, 1'b0, 4'b0001);
        cyc(w, 4'b0000, 1'b0, 4'b0001);
        cyc(w, 4'b0001, 1'b1, 4'b0000);
        cyc(w, 4'b0001, 1'b1, 4'b0000);
        cyc(w, 4'b0001, 1'b0, 4'b0010);
        cyc(w, 4'b0000, 1'b0, 4'b0000);
        for (int i = 0; i < 6; i++) cyc(w, 4'b0000, 1'b0, 4'b0001);
        cyc(w, 4'b0000, 1'b0, 4'b0000);

        // Weight change mid-burst keeps the old credit; next grant is a max burst of 7.
        do_reset();
        cyc(wv(0, 0, 0, 2), 4'b0000, 1'b0, 4'b0000);
        cyc(wv(0, 0, 0, 2), 4'b0000, 1'b0, 4'b0001);
        cyc(wv(0, 0, 0, 7), 4'b0000, 1'b0, 4'b0001);
        cyc(wv(0, 0, 0, 7), 4'b0000, 1'b0, 4'b0000);
        for (int i = 0; i < 7; i++) cyc(wv(0, 0, 0, 7), 4'b0000, 1'b0, 4'b0001);
        cyc(wv(0, 0, 0, 7), 4'b0000, 1'b0, 4'b0000);

        // Reset mid-burst (q0 weight 5, two pops done), then restart at q0.
        do_reset();
        w = wv(0, 0, 0, 5);
        cyc(w, 4'b0000, 1'b0, 4'b0000);
        cyc(w, 4'b0000, 1'b0, 4'b0001);
        cyc(w, 4'b0000, 1'b0, 4'b0001);
        do_reset();
        w = wv(1, 1, 1, 1);
        cyc(w, 4'b0000, 1'b0, 4'b0000);
        cyc(w, 4'b0000, 1'b0, 4'b0001);
        cyc(w, 4'b0000, 1'b0, 4'b0000);

        // Let the monitor drain the scoreboard, bounded.
        for (int i = 0; i < 10 && sb.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (sb.size() != 0) begin
            n_checks++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/wrr_pop_scheduler.md
Name: wrr_pop_scheduler

Overview:
Weighted round-robin scheduler that drains four input FIFOs into one shared downstream FIFO. It sits between the per-queue FIFOs and the shared output path, and decides which FIFO is popped each cycle. Each granted queue may pop up to its programmed weight in consecutive cycles. The block honours the FIFO empty flags and downstream back-pressure, and reports the id of the popped data one cycle later, in line with the FIFO read latency of 1.

Parameters:
NUM_Q, 4, number of queues; only 4 supported; sets empty/pop widths.
ID_W, 2, queue id width, log2(NUM_Q).
WGT_W, 3, per-queue weight width; weight 0 disables a queue.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
empty  input  4  FIFO empty flags; bit i = queue i
weights  input  12  queue i weight at [3i+2:3i]; may change at any time
down_almost_full  input  1  downstream cannot accept data this cycle
pop  output  4  one-hot-or-zero FIFO pop, combinational from state and inputs
id  output  2  currently granted queue (registered cur)
out_valid  output  1  registered: data from a pop is on the FIFO outputs this cycle
out_id  output  2  registered: queue that produced out_valid data

Behaviour:
- Reset (async, immediate): state=IDLE, cur=3 (first search starts at q0), credit=0, id=0, out_valid=0, out_id=0. pop is 0 while reset is high.
- Eligibility: elig[i] = ~empty[i] & (weight[i]!=0).
- IDLE:
  - pop=0.
  - Search elig in order cur+1, cur+2, cur+3, cur (mod 4, wrap 3->0).
  - First hit w: next state SERVE, cur<=w, credit<=weight[w].
  - No hit: stay IDLE, cur unchanged.
  - down_almost_full does not block the grant.
- SERVE:
  - fire = ~empty[cur] & ~down_almost_full; pop[cur]=fire, other bits 0.
  - fire & credit>1: credit--, stay SERVE.
  - fire & credit==1: credit<=0, go IDLE.
  - ~fire & empty[cur]: queue drained; go IDLE, remaining credit discarded.
  - ~fire & ~empty[cur] (back-pressure): hold state and credit; no timeout.
- Grant latency: 1 cycle from IDLE decision to first pop. There is always one bubble cycle between bursts, including when the same queue is regranted.
- id = cur; its value is meaningful only while pop!=0.
- out_valid <= |pop; out_id <= cur (every cycle).
- Weight changes take effect at the next grant only; a weight change during SERVE does not alter credit.
- Empty and almost_full rising in the same cycle: the empty rule wins, so go IDLE.
- Max burst = 7 pops (weight 7); credit never underflows or wraps.
- pop is never asserted to an empty FIFO or while down_almost_full=1.

Optional Feature:
WRR_STATS_EN
- Defined: adds output pop_count[31:0], four 8-bit per-queue counters (queue i at [8i+7:8i]).
  - Counter i increments on pop[i] and saturates at 255.
  - Counters clear on reset and on the 1-cycle input stats_clr. When clr and pop coincide, clear wins.
- Undefined: pop_count and stats_clr do not exist; no counter logic is built.

Test Plan:
- Reset asserted mid-burst (q0 weight 5, 2 pops done) -> same cycle pop=0, out_valid=0; after release the first grant goes to q0 (cur=3 start).
- Weights all 1, all queues non-empty, almost_full=0 -> pop per cycle 0001,0000,0010,0000,0100,0000,1000,0000,0001; out_valid/out_id trail pop by 1 cycle.
- weights={q3=1,q2=1,q1=1,q0=3}, all non-empty -> pop 0001 x3, 0000, 0010, 0000, 0100, ...; id=0 during the q0 burst.
- q1 granted weight 4, down_almost_full=1 for 3 cycles after the first pop -> pop=0000 for 3 cycles, then 0010 x3 more; 4 pops total.
- empty[2]=1, weight[3]=0, q0/q1 weight 2 -> only q0/q1 are served, alternating 0001,0001,0000,0010,0010,0000; pop[2] and pop[3] are never asserted.
- q0 weight 6 and empty[0] rises after 2 pops -> next cycle IDLE, q1 granted; the remaining 4 credits are discarded.
